button_step_conditioner: RTL

- Upstream conditioning stage for the board's up/down LED counter.
- Takes the raw, bouncing, asynchronous push button and slide switch and synchronises both to the system clock, then debounces them.
- Emits mutually exclusive one-cycle upPulse/downPulse strobes: one per accepted press, plus optional auto-repeat while the button is held.
- The downstream counter runs on clk and adds or subtracts 1 per strobe; it never uses the button as a clock.

---
 rtl/button_step_conditioner.sv | 132 +++++++++++++
 1 files changed

// File: rtl/button_step_conditioner.sv
// button_step_conditioner: synchronise, debounce and strobe a raw push button and direction switch
//   clk         system clock, all state on the rising edge
//   rstN        asynchronous active-low reset
//   pushButton  raw bouncing button, 1 = pressed
//   slideSwitch raw direction switch, 1 = count up
//   upPulse     one-cycle increment strobe
//   downPulse   one-cycle decrement strobe
//   buttonLevel debounced button level
//   dirLevel    debounced switch level
module button_step_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000,
    parameter int CNT_W           = 26
) (
    input  logic clk,
    input  logic rstN,
    input  logic pushButton,
    input  logic slideSwitch,
    output logic upPulse,
    output logic downPulse,
    output logic buttonLevel,
    output logic dirLevel
);
    typedef enum logic [2:0] {IDLE, PRESS_WAIT, HELD, REPEAT, RELEASE_WAIT} state_t;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam bit               REP_EN    = REPEAT_CYCLES != 0;

    state_t           state, state_n;
    logic [CNT_W-1:0] tmr, tmr_n, stmr;
    logic             b_meta, b_sync, s_meta, s_sync, strobe;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            {b_meta, b_sync, s_meta, s_sync} <= '0;
        end else begin
            b_meta <= pushButton;
            b_sync <= b_meta;
            s_meta <= slideSwitch;
            s_sync <= s_meta;
        end
    end

    always_comb begin
        state_n = state;
        tmr_n   = tmr + ONE;
        strobe  = 1'b0;
        case (state)
            IDLE: begin
                state_n = b_sync ? PRESS_WAIT : IDLE;
                tmr_n   = b_sync ? ONE : '0;
            end
            PRESS_WAIT: begin
                if (!b_sync) begin
                    state_n = IDLE;
                    tmr_n   = '0;
                end else if (tmr == DEB_LAST) begin
                    state_n = HELD;
                    tmr_n   = '0;
                    strobe  = 1'b1;
                end
            end
            HELD: begin
                if (!b_sync) begin
                    state_n = RELEASE_WAIT;
                    tmr_n   = ONE;
                end else if (REP_EN && tmr == HOLD_LAST) begin
                    state_n = REPEAT;
                    tmr_n   = '0;
                    strobe  = 1'b1;
                end else if (tmr == '1) begin
                    // with auto-repeat disabled the hold timer parks at full scale
                    tmr_n = tmr;
                end
            end
            REPEAT: begin
                if (!b_sync) begin
                    state_n = RELEASE_WAIT;
                    tmr_n   = ONE;
                end else if (tmr == REP_LAST) begin
                    tmr_n  = '0;
                    strobe = 1'b1;
                end
            end
            RELEASE_WAIT: begin
                // a bounce back high re-enters HELD and restarts the hold delay
                if (b_sync) begin
                    state_n = HELD;
                    tmr_n   = '0;
                end else if (tmr == DEB_LAST) begin
                    state_n = IDLE;
                    tmr_n   = '0;
                end
            end
            default: begin
                state_n = IDLE;
                tmr_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state       <= IDLE;
            tmr         <= '0;
            stmr        <= '0;
            dirLevel    <= 1'b0;
            upPulse     <= 1'b0;
            downPulse   <= 1'b0;
            buttonLevel <= 1'b0;
        end else begin
            state       <= state_n;
            tmr         <= tmr_n;
            // strobe direction uses the dirLevel held now, not one accepted on this edge
            upPulse     <= strobe & dirLevel;
            downPulse   <= strobe & ~dirLevel;
            buttonLevel <= state_n inside {HELD, REPEAT, RELEASE_WAIT};
            if (s_sync == dirLevel) begin
                stmr <= '0;
            end else if (stmr == DEB_LAST) begin
                dirLevel <= s_sync;
                stmr     <= '0;
            end else begin
                stmr <= stmr + ONE;
            end
        end
    end
endmodule
